// File: rtl/bcd_ndigit_if.sv
// Handshake and result bus between a requester and the bcd_ndigit converter.
interface bcd_ndigit_if #(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
);
   logic                  start;
   logic [WIDTH-1:0]      value;
   logic                  busy;
   logic                  done;
   logic                  ovf;
   logic [4*DIGITS-1:0]   bcd;

   modport master (output start, output value,
                   input  busy,  input  done, input ovf, input bcd);
   modport slave  (input  start, input  value,
                   output busy,  output done, output ovf, output bcd);
endinterface

// File: rtl/bcd_ndigit.sv
// Sequential binary-to-BCD converter (double dabble) for the seven-segment
// display path. One operand bit is processed per cycle; results are only
// published in FINISH so the display never sees partial digits.
// Digit code 4'hF means "blank".
module bcd_ndigit #(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4,
   parameter bit BLANK  = 1'b1,
   parameter bit AUTO   = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   bcd_ndigit_if.slave    bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t            state_q,  state_d;
   logic [WIDTH-1:0]  opnd_q,   opnd_d;
   logic [BW-1:0]     scr_q,    scr_d;
   logic              sticky_q, sticky_d;
   logic [CW-1:0]     cnt_q,    cnt_d;
   logic [WIDTH-1:0]  last_q,   last_d;
   logic              pend_q,   pend_d;
   logic              busy_q,   busy_d;
   logic              done_q,   done_d;
   logic              ovf_q,    ovf_d;
   logic [BW-1:0]     bcd_q,    bcd_d;

   logic              trigger_s;
   logic [BW-1:0]     adj_s;

   // Add 3 to every digit that is 5 or more, ahead of the shift.
   function automatic logic [BW-1:0] adjust_digits(input logic [BW-1:0] s);
      logic [BW-1:0] r;
      r = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (s[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = s[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = s[4*i +: 4];
         end
      end
      return r;
   endfunction

   // Replace leading zero digits with blank; the ones digit always shows.
   function automatic logic [BW-1:0] blank_leading(input logic [BW-1:0] s);
      logic [BW-1:0] r;
      logic          lead;
      r    = s;
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead && (s[4*i +: 4] == 4'h0)) begin
            r[4*i +: 4] = 4'hF;
         end else begin
            lead = 1'b0;
         end
      end
      return r;
   endfunction

   assign trigger_s = AUTO ? ((bus.value != last_q) || pend_q) : bus.start;
   assign adj_s     = adjust_digits(scr_q);

   // Next-state and datapath decisions for IDLE / SHIFT / FINISH.
   always_comb begin
      state_d  = state_q;
      opnd_d   = opnd_q;
      scr_d    = scr_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      pend_d   = pend_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ovf_d    = ovf_q;
      bcd_d    = bcd_q;
      case (state_q)
         S_IDLE: begin
            if (trigger_s) begin
               opnd_d   = bus.value;
               scr_d    = '0;
               sticky_d = 1'b0;
               cnt_d    = CW'(WIDTH);
               last_d   = bus.value;
               pend_d   = 1'b0;
               busy_d   = 1'b1;
               state_d  = S_SHIFT;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_SHIFT: begin
            // The bit leaving the top digit is lost precision: remember it.
            scr_d    = {adj_s[BW-2:0], opnd_q[WIDTH-1]};
            opnd_d   = {opnd_q[WIDTH-2:0], 1'b0};
            sticky_d = sticky_q | adj_s[BW-1];
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_FINISH;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_FINISH: begin
            if (sticky_q) begin
               bcd_d = {DIGITS{4'h9}};
               ovf_d = 1'b1;
            end else begin
               bcd_d = BLANK ? blank_leading(scr_q) : scr_q;
               ovf_d = 1'b0;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         opnd_q   <= '0;
         scr_q    <= '0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
         last_q   <= '0;
         pend_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         bcd_q    <= {DIGITS{4'hF}};
      end else begin
         state_q  <= state_d;
         opnd_q   <= opnd_d;
         scr_q    <= scr_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         pend_q   <= pend_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         bcd_q    <= bcd_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.ovf  = ovf_q;
   assign bus.bcd  = bcd_q;

endmodule

// File: doc/bcd_ndigit.md
# bcd_ndigit

Parametrised sequential binary-to-BCD converter for the seven-segment display path. It converts a WIDTH-bit unsigned value into DIGITS BCD digits using iterative shift-add-3 (double dabble). Options cover leading-zero blanking, overflow saturation and automatic re-conversion on input change. The packed digit bus feeds the display multiplexer directly; digit code 4'hF means "blank".

## Interface
- WIDTH, 14, bit width of the binary input (≥ 4)
- DIGITS, 4, number of BCD digits produced (≥ 1)
- BLANK, 1, 1 = replace leading zeros with 4'hF; 0 = show all digits
- AUTO, 0, 1 = self-start whenever `value` differs from the last converted value; 0 = convert only on `start`

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- start  input  1  conversion request; sampled only in IDLE; ignored when AUTO=1
- value  input  WIDTH  unsigned binary operand; captured on the accepting edge
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when `bcd`/`ovf` update
- ovf  output  1  value ≥ 10^DIGITS for the last conversion
- bcd  output  4*DIGITS  packed digits; digit 0 (ones) at [3:0], digit i at [4i+3:4i]

## Operation
- Reset values (rst=0 at a rising edge): state IDLE, `busy`=0, `done`=0, `ovf`=0, every digit of `bcd`=4'hF, AUTO last-value register=0, and AUTO pending flag set so the first post-reset value is converted.
- States:
  - IDLE: on trigger, latch `value` into the shift register, clear the 4*DIGITS scratch register, clear the sticky overflow bit, set bit counter = WIDTH, go to SHIFT. Trigger is `start`=1 (AUTO=0), or `value` ≠ last converted value or pending flag (AUTO=1).
  - SHIFT: per cycle, add 3 to each scratch digit ≥ 5, then shift {scratch, operand} left one bit. A 1 shifted out of the scratch MSB sets sticky overflow. Decrement the counter. After the WIDTH-th shift, go to FINISH.
  - FINISH: register outputs, pulse `done`, return to IDLE.
- FINISH output rules:
  - Overflow: `bcd` = all 4'h9, `ovf`=1, no blanking.
  - Otherwise `ovf`=0 and, with BLANK=1, digits from DIGITS-1 downward that are 0 become 4'hF up to the first non-zero digit. Digit 0 is never blanked.
- `bcd` and `ovf` change only in FINISH, so the display never sees intermediate values.
- AUTO: the last-value register updates with the captured operand on acceptance. A `value` change during a conversion is picked up in the next IDLE cycle.
- Any counter width ≥ clog2(WIDTH+1).

## Timing
- Accepting edge = edge 0. `busy`=1 from edge 0. SHIFT occupies edges 1..WIDTH. FINISH at edge WIDTH+1, where `bcd`/`ovf` update, `done`=1 for exactly one cycle and `busy`=0.
- Latency = WIDTH+1 cycles from accept to `done`. Throughput is one conversion per WIDTH+2 cycles: a `start` held high re-triggers in the IDLE cycle right after `done`.
- `start` while busy (SHIFT or FINISH) is ignored, not queued.
- Reset mid-conversion aborts immediately with no `done` pulse, and outputs return to reset values.
- `done` and a new accept never coincide; IDLE lasts at least one cycle.

## Test plan
- Reset, then `start` with value=1234 (WIDTH=14, DIGITS=4, BLANK=1) -> `busy` high for 15 cycles, `done` pulse at edge 15, `bcd`=16'h1234, `ovf`=0.
- value=7 -> `bcd`=16'hFFF7. value=0 -> 16'hFFF0. value=9999 -> 16'h9999. Repeat with BLANK=0: 7 -> 16'h0007.
- value=10000 and value=16383 -> `bcd`=16'h9999, `ovf`=1. A following value=42 -> `ovf` back to 0, `bcd`=16'hFF42.
- `start` pulsed at edges 3 and 15 of a conversion of 500 -> ignored, exactly one `done`, `bcd`=16'hF500.
- Assert `rst`=0 at edge 8 of a conversion -> no `done`, `bcd`=16'hFFFF, `busy`=0. A new `start` then converts normally.
- AUTO=1: after reset with value=305, conversion starts unprompted -> 16'hF305. Change to 306 at SHIFT edge 5 -> the current result 16'hF305 completes, then a second conversion yields 16'hF306. Constant value -> no further `done`.
